// File: rtl/dac_spi_master.sv
// SPI mode 0, MSB-first serialiser for one DAC sample per chip-select frame.
// Samples arrive over valid/ready; SCLK rate and inter-frame gap are parameters.
module dac_spi_master #(
  parameter int DATA_W   = 16,
  parameter int CLK_DIV  = 4,
  parameter int IDLE_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              dac_mosi,
  output logic              dac_sclk,
  output logic              dac_cs_n,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);

  logic [2:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  // Holds the bits still to be sent; the bit on the wire lives in mosi_q.
  logic [DATA_W-2:0] sh_q, sh_d;
  logic              mosi_q, mosi_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              div_end;

  assign s_ready = rst_n && (state_q == S_IDLE) && en;
  assign div_end = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sh_d    = sh_q;
    mosi_d  = mosi_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (s_valid && s_ready) begin
          state_d = S_SETUP;
          sh_d    = s_data[DATA_W-2:0];
          mosi_d  = s_data[DATA_W-1];
          cs_n_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      S_SETUP: begin
        if (div_end) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (!div_end) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (sclk_q) begin
            // Falling edge: present the next bit; bit 0 stays on the wire through HOLD.
            sclk_d = 1'b0;
            if (bit_q != BIT_LAST) begin
              mosi_d = sh_q[DATA_W-2];
              sh_d   = sh_q << 1;
            end
          end else if (bit_q == BIT_LAST) begin
            state_d = S_HOLD;
          end else begin
            bit_d  = bit_q + 1'b1;
            sclk_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (div_end) begin
          div_d   = '0;
          gap_d   = '0;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          bit_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sh_q    <= '0;
      mosi_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
      mosi_q  <= mosi_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dac_mosi   = mosi_q;
  assign dac_sclk   = sclk_q;
  assign dac_cs_n   = cs_n_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_dac_spi_master.sv
// Directed bench for dac_spi_master: a default instance and a fast 8-bit instance,
// each watched by a pin-level monitor that decodes frames from the SPI wires.
module tb_dac_spi_master;

  logic clk = 1'b0;
  logic rst_n;
  logic en, s_valid, s_ready, dac_mosi, dac_sclk, dac_cs_n, busy, frame_done;
  logic [15:0] s_data;
  logic en_b, s_valid_b, s_ready_b, mosi_b, sclk_b, cs_n_b, busy_b, done_b_o;
  logic [7:0] s_data_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dac_spi_master dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .dac_mosi(dac_mosi), .dac_sclk(dac_sclk),
    .dac_cs_n(dac_cs_n), .busy(busy), .frame_done(frame_done)
  );

  dac_spi_master #(.DATA_W(8), .CLK_DIV(1), .IDLE_GAP(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .s_data(s_data_b), .s_valid(s_valid_b),
    .s_ready(s_ready_b), .dac_mosi(mosi_b), .dac_sclk(sclk_b),
    .dac_cs_n(cs_n_b), .busy(busy_b), .frame_done(done_b_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor state for instance A
  int cyc = 0;
  logic [15:0] rx_a;
  int rises_a, low_a, hi_a, done_a, fd_a, hs_a, bad_rise_a, fd_mis_a;
  logic psclk_a, pcs_a;
  logic [15:0] rx_h [16];
  int rises_h [16], low_h [16], gap_h [16], hs_cyc [16];

  // Monitor state for instance B
  logic [7:0] rx_b;
  int rises_b, low_b, hi_b, done_b, hs_b, bad_rise_b, last_rise_b, rise_per_b;
  logic psclk_b, pcs_b;
  logic [7:0] rx_hb [16];
  int rises_hb [16], low_hb [16], gap_hb [16], hs_cyc_b [16];

  initial begin
    rx_a = 0; rises_a = 0; low_a = 0; hi_a = 0; done_a = 0; fd_a = 0; hs_a = 0;
    bad_rise_a = 0; fd_mis_a = 0; psclk_a = 0; pcs_a = 1;
    rx_b = 0; rises_b = 0; low_b = 0; hi_b = 0; done_b = 0; hs_b = 0;
    bad_rise_b = 0; last_rise_b = 0; rise_per_b = 0; psclk_b = 0; pcs_b = 1;
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      rx_a = 0; rises_a = 0; low_a = 0; hi_a = 0;
      rx_b = 0; rises_b = 0; low_b = 0; hi_b = 0;
    end else begin
      if (s_valid && s_ready) begin
        if (hs_a < 16) hs_cyc[hs_a] = cyc;
        hs_a++;
      end
      if (dac_sclk && !psclk_a) begin
        if (dac_cs_n) bad_rise_a++;
        else begin rx_a = {rx_a[14:0], dac_mosi}; rises_a++; end
      end
      if (frame_done) fd_a++;
      if (!dac_cs_n) begin
        if (pcs_a) gap_h[done_a % 16] = hi_a;
        low_a++;
      end else begin
        if (!pcs_a) begin
          rx_h[done_a % 16] = rx_a; rises_h[done_a % 16] = rises_a; low_h[done_a % 16] = low_a;
          $display("A frame %0d: data=%h rises=%0d cs_low=%0d", done_a, rx_a, rises_a, low_a);
          if (!frame_done) fd_mis_a++;
          done_a++;
          rx_a = 0; rises_a = 0; low_a = 0; hi_a = 0;
        end
        hi_a++;
      end

      if (s_valid_b && s_ready_b) begin
        if (hs_b < 16) hs_cyc_b[hs_b] = cyc;
        hs_b++;
      end
      if (sclk_b && !psclk_b) begin
        if (cs_n_b) bad_rise_b++;
        else begin
          if (rises_b > 0) rise_per_b = cyc - last_rise_b;
          last_rise_b = cyc;
          rx_b = {rx_b[6:0], mosi_b}; rises_b++;
        end
      end
      if (!cs_n_b) begin
        if (pcs_b) gap_hb[done_b % 16] = hi_b;
        low_b++;
      end else begin
        if (!pcs_b) begin
          rx_hb[done_b % 16] = rx_b; rises_hb[done_b % 16] = rises_b; low_hb[done_b % 16] = low_b;
          $display("B frame %0d: data=%h rises=%0d cs_low=%0d", done_b, rx_b, rises_b, low_b);
          done_b++;
          rx_b = 0; rises_b = 0; low_b = 0; hi_b = 0;
        end
        hi_b++;
      end
    end
    psclk_a = dac_sclk; pcs_a = dac_cs_n;
    psclk_b = sclk_b;   pcs_b = cs_n_b;
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  function automatic int mon_val(input int sel);
    case (sel)
      0: return done_a;
      1: return hs_a;
      2: return rises_a;
      3: return done_b;
      default: return hs_b;
    endcase
  endfunction

  task automatic wait_until(input int sel, input int target, input string tag);
    int n;
    n = 0;
    while (mon_val(sel) < target && n < 2000) begin tick(); n++; end
    if (mon_val(sel) < target) check_eq(tag, 32'(mon_val(sel)), 32'(target));
  endtask

  // One handshake on instance A, then drop s_valid
  task automatic send_a(input logic [15:0] d);
    @(posedge clk); #1;
    s_data = d; s_valid = 1'b1;
    wait_until(1, hs_a + 1, "hs_timeout");
    @(posedge clk); #1;
    s_valid = 1'b0;
    check_eq("busy_rise", 32'(busy), 1);
  endtask

  int base, hb;

  initial begin
    rst_n = 0; en = 1; s_valid = 0; s_data = 0;
    en_b = 1; s_valid_b = 0; s_data_b = 0;
    repeat (3) tick();
    check_eq("rst_cs_n", 32'(dac_cs_n), 1);
    check_eq("rst_sclk", 32'(dac_sclk), 0);
    check_eq("rst_mosi", 32'(dac_mosi), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(frame_done), 0);
    check_eq("rst_ready", 32'(s_ready), 0);
    rst_n = 1; #1;
    check_eq("ready_after_rst", 32'(s_ready), 1);

    // Single A5C3 frame
    base = done_a;
    send_a(16'hA5C3);
    wait_until(0, base + 1, "t1_timeout");
    check_eq("t1_data", 32'(rx_h[base]), 'hA5C3);
    check_eq("t1_rises", 32'(rises_h[base]), 16);
    check_eq("t1_cs_low", 32'(low_h[base]), 136);
    check_eq("t1_fd_count", 32'(fd_a), 32'(done_a));
    check_eq("t1_fd_align", 32'(fd_mis_a), 0);
    repeat (5) tick();
    check_eq("t1_busy_idle", 32'(busy), 0);

    // Back-to-back frames with s_valid held high
    base = done_a; hb = hs_a;
    @(posedge clk); #1;
    s_data = 16'h0001; s_valid = 1;
    wait_until(1, hb + 1, "t2_hs1");
    @(posedge clk); #1 s_data = 16'hFFFF;
    wait_until(1, hb + 2, "t2_hs2");
    @(posedge clk); #1 s_valid = 0;
    wait_until(0, base + 2, "t2_timeout");
    check_eq("t2_data0", 32'(rx_h[base]), 'h0001);
    check_eq("t2_data1", 32'(rx_h[base + 1]), 'hFFFF);
    check_eq("t2_gap", 32'(gap_h[base + 1]), 3);
    check_eq("t2_period", 32'(hs_cyc[hb + 1] - hs_cyc[hb]), 139);

    // s_data changes mid-frame
    base = done_a;
    send_a(16'h8001);
    repeat (20) tick();
    @(posedge clk); #1 s_data = 16'h0000;
    wait_until(0, base + 1, "t3_timeout");
    check_eq("t3_data", 32'(rx_h[base]), 'h8001);

    // en dropped at SCLK edge 5
    base = done_a; hb = hs_a;
    @(posedge clk); #1;
    s_data = 16'h5A5A; s_valid = 1;
    wait_until(1, hb + 1, "t4_hs1");
    wait_until(2, 5, "t4_rise5");
    @(posedge clk); #1 en = 0;
    wait_until(0, base + 1, "t4_timeout");
    check_eq("t4_data", 32'(rx_h[base]), 'h5A5A);
    check_eq("t4_rises", 32'(rises_h[base]), 16);
    repeat (20) tick();
    check_eq("t4_ready_low", 32'(s_ready), 0);
    check_eq("t4_no_hs", 32'(hs_a), 32'(hb + 1));
    @(posedge clk); #1;
    s_data = 16'h3C3C; en = 1;
    wait_until(1, hb + 2, "t4_hs2");
    @(posedge clk); #1 s_valid = 0;
    wait_until(0, base + 2, "t4_timeout2");
    check_eq("t4_resume", 32'(rx_h[base + 1]), 'h3C3C);

    // Reset mid-frame at bit 8
    base = done_a;
    send_a(16'hFFFF);
    wait_until(2, 8, "t5_rise8");
    check_eq("t5_pre_cs", 32'(dac_cs_n), 0);
    rst_n = 0; #1;
    check_eq("t5_cs_n", 32'(dac_cs_n), 1);
    check_eq("t5_sclk", 32'(dac_sclk), 0);
    check_eq("t5_mosi", 32'(dac_mosi), 0);
    check_eq("t5_busy", 32'(busy), 0);
    check_eq("t5_ready", 32'(s_ready), 0);
    repeat (2) tick();
    rst_n = 1;
    tick();
    check_eq("t5_no_frame", 32'(done_a), 32'(base));
    send_a(16'h1234);
    wait_until(0, base + 1, "t5_timeout");
    check_eq("t5_data", 32'(rx_h[base]), 'h1234);
    check_eq("t5_rises", 32'(rises_h[base]), 16);
    check_eq("t5_cs_low", 32'(low_h[base]), 136);
    check_eq("a_bad_rise", 32'(bad_rise_a), 0);

    // Fast instance: DATA_W=8, CLK_DIV=1, IDLE_GAP=1
    base = done_b; hb = hs_b;
    @(posedge clk); #1;
    s_data_b = 8'h3C; s_valid_b = 1;
    wait_until(4, hb + 1, "t6_hs1");
    @(posedge clk); #1 s_data_b = 8'hA5;
    wait_until(4, hb + 2, "t6_hs2");
    @(posedge clk); #1 s_valid_b = 0;
    wait_until(3, base + 2, "t6_timeout");
    check_eq("t6_data0", 32'(rx_hb[base]), 'h3C);
    check_eq("t6_data1", 32'(rx_hb[base + 1]), 'hA5);
    check_eq("t6_rises", 32'(rises_hb[base]), 8);
    check_eq("t6_cs_low", 32'(low_hb[base]), 18);
    check_eq("t6_sclk_per", 32'(rise_per_b), 2);
    check_eq("t6_gap", 32'(gap_hb[base + 1]), 2);
    check_eq("t6_period", 32'(hs_cyc_b[hb + 1] - hs_cyc_b[hb]), 20);
    check_eq("b_bad_rise", 32'(bad_rise_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
